// File: rtl/http_tx_sched.sv
// http_tx_sched -- multi-channel HTTP response transmit scheduler.
//
// Arbitrates N_CH response producers round-robin onto one TCP transmit
// port. Each granted response issues tx_meta, waits for the stack's
// tx_status reply, re-issues the meta on refusal up to MAX_RETRY times,
// then either forwards the body to tx_data or drains and discards it.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   rsp_valid/ready/sid/len   per-channel response metadata (sid/len packed per channel)
//   body_data/keep/last/valid/ready  per-channel body streams
//   tx_meta_*                 {len, sid} request to the TCP stack
//   tx_status_*               {err[1:0], len, sid} reply; err==0 accepted
//   tx_data_*                 body stream to the TCP stack
//   busy                      FSM not idle
//   sent_count, drop_count    statistics (zero unless HTTP_TX_SCHED_STATS_EN)
//
// Build option: define HTTP_TX_SCHED_STATS_EN to implement the counters.
module http_tx_sched #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 512,
    parameter int SID_W     = 16,
    parameter int LEN_W     = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [N_CH-1:0]           rsp_valid,
    output logic [N_CH-1:0]           rsp_ready,
    input  logic [N_CH*SID_W-1:0]     rsp_sid,
    input  logic [N_CH*LEN_W-1:0]     rsp_len,
    input  logic [N_CH*DATA_W-1:0]    body_data,
    input  logic [N_CH*DATA_W/8-1:0]  body_keep,
    input  logic [N_CH-1:0]           body_last,
    input  logic [N_CH-1:0]           body_valid,
    output logic [N_CH-1:0]           body_ready,
    output logic [LEN_W+SID_W-1:0]    tx_meta_data,
    output logic                      tx_meta_valid,
    input  logic                      tx_meta_ready,
    input  logic [2+LEN_W+SID_W-1:0]  tx_status_data,
    input  logic                      tx_status_valid,
    output logic                      tx_status_ready,
    output logic [DATA_W-1:0]         tx_data_data,
    output logic [DATA_W/8-1:0]       tx_data_keep,
    output logic                      tx_data_last,
    output logic                      tx_data_valid,
    input  logic                      tx_data_ready,
    output logic                      busy,
    output logic [31:0]               sent_count,
    output logic [31:0]               drop_count
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_META, S_STATUS, S_DATA, S_DROP} state_t;

    state_t           r_state;
    logic [CH_W-1:0]  r_last;
    logic [CH_W-1:0]  r_g;
    logic [SID_W-1:0] r_sid;
    logic [LEN_W-1:0] r_len;
    logic [3:0]       r_retry;

    logic             w_found;
    logic [CH_W-1:0]  w_grant;
    logic [CH_W:0]    w_idx;
    logic [LEN_W-1:0] w_len;
    logic [SID_W-1:0] w_sid;
    logic [1:0]       w_err;
    logic             w_in_data;
    logic             w_beat_last;

    // Round-robin search starting one past the last served channel.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = {1'b0, r_last} + (CH_W+1)'(k + 1);
            if (w_idx >= (CH_W+1)'(N_CH))
                w_idx = w_idx - (CH_W+1)'(N_CH);
            if (!w_found && rsp_valid[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[CH_W-1:0];
            end
        end
    end

    assign w_len = rsp_len[w_grant*LEN_W +: LEN_W];
    assign w_sid = rsp_sid[w_grant*SID_W +: SID_W];
    assign w_err = tx_status_data[2+LEN_W+SID_W-1 -: 2];

    // Only err matters; the echoed len/sid are not cross-checked.
    logic w_unused_status;
    assign w_unused_status = &{1'b0, tx_status_data[LEN_W+SID_W-1:0]};

    // rsp_ready is gated by reset so nothing is accepted while held in reset.
    always_comb begin
        rsp_ready  = '0;
        body_ready = '0;
        if (ap_rst_n && r_state == S_IDLE && w_found)
            rsp_ready[w_grant] = 1'b1;
        if (r_state == S_DATA)
            body_ready[r_g] = tx_data_ready;
        if (r_state == S_DROP)
            body_ready[r_g] = 1'b1;
    end

    // Body pass-through for the granted channel while in DATA only.
    assign w_in_data     = (r_state == S_DATA);
    assign tx_data_valid = w_in_data & body_valid[r_g];
    assign tx_data_data  = w_in_data ? body_data[r_g*DATA_W +: DATA_W] : '0;
    assign tx_data_keep  = w_in_data ? body_keep[r_g*KEEP_W +: KEEP_W] : '0;
    assign tx_data_last  = w_in_data & body_last[r_g];

    assign tx_meta_valid   = (r_state == S_META);
    assign tx_meta_data    = {r_len, r_sid};
    assign tx_status_ready = (r_state == S_STATUS);
    assign busy            = (r_state != S_IDLE);

    assign w_beat_last = body_valid[r_g] & body_ready[r_g] & body_last[r_g];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
            r_last  <= CH_W'(N_CH - 1);
            r_g     <= '0;
            r_sid   <= '0;
            r_len   <= '0;
            r_retry <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_g     <= w_grant;
                    r_sid   <= w_sid;
                    r_len   <= w_len;
                    r_retry <= '0;
                    // Empty responses complete without touching the stack.
                    if (w_len == '0) r_last  <= w_grant;
                    else             r_state <= S_META;
                end
                S_META: if (tx_meta_ready) r_state <= S_STATUS;
                S_STATUS: if (tx_status_valid) begin
                    if (w_err == 2'b00)
                        r_state <= S_DATA;
                    else if (r_retry < 4'(MAX_RETRY)) begin
                        r_retry <= r_retry + 4'd1;
                        r_state <= S_META;
                    end else
                        r_state <= S_DROP;
                end
                S_DATA, S_DROP: if (w_beat_last) begin
                    r_last  <= r_g;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HTTP_TX_SCHED_STATS_EN
    logic [31:0] r_sent;
    logic [31:0] r_drop;
    logic        w_sent_inc;
    logic        w_drop_inc;

    assign w_sent_inc = (r_state == S_IDLE && w_found && w_len == '0) ||
                        (r_state == S_DATA && w_beat_last);
    assign w_drop_inc = (r_state == S_DROP && w_beat_last);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            if (w_sent_inc) r_sent <= r_sent + 32'd1;
            if (w_drop_inc) r_drop <= r_drop + 32'd1;
        end
    end

    assign sent_count = r_sent;
    assign drop_count = r_drop;
`else
    assign sent_count = '0;
    assign drop_count = '0;
`endif

endmodule

// File: doc/http_tx_sched.md
# http_tx_sched

Multi-channel HTTP response transmit scheduler. Sits between N HTTP response producers, each supplying response metadata and a body stream, and the single TCP transmit port of the network stack (tx_meta, tx_status, tx_data). The block arbitrates round-robin across channels and handshakes each response with the TCP stack's transmit-status reply. It retries refused transmissions a bounded number of times, then forwards or discards the body.

## Interface
Parameters:
- N_CH, 4: number of response channels (1..16)
- DATA_W, 512: body / tx data width in bits (multiple of 8)
- SID_W, 16: TCP session id width
- LEN_W, 16: response length width, in bytes
- MAX_RETRY, 3: tx_meta re-issues after a refused status before the response is dropped (0..15)

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- rsp_valid  in  N_CH  per-channel response metadata valid
- rsp_ready  out  N_CH  per-channel response metadata accept
- rsp_sid  in  N_CH*SID_W  session id, channel i at [i*SID_W +: SID_W]
- rsp_len  in  N_CH*LEN_W  body length in bytes, channel i at [i*LEN_W +: LEN_W]
- body_data  in  N_CH*DATA_W  body beats
- body_keep  in  N_CH*DATA_W/8  byte enables
- body_last  in  N_CH  last body beat
- body_valid  in  N_CH  body beat valid
- body_ready  out  N_CH  body beat accept
- tx_meta_data  out  LEN_W+SID_W  {len, sid}
- tx_meta_valid  out  1; tx_meta_ready  in  1
- tx_status_data  in  2+LEN_W+SID_W  {err[1:0], len, sid}; err==0 means accepted
- tx_status_valid  in  1; tx_status_ready  out  1
- tx_data_data  out  DATA_W; tx_data_keep  out  DATA_W/8; tx_data_last  out  1
- tx_data_valid  out  1; tx_data_ready  in  1
- busy  out  1  FSM not in IDLE
- sent_count  out  32  responses fully transmitted
- drop_count  out  32  responses dropped after retry exhaustion

## Operation
- FSM states: IDLE, META, STATUS, DATA, DROP.
- IDLE:
  - Round-robin grant. Search starts at (last_grant+1) mod N_CH; the lowest index at or after it with rsp_valid wins.
  - rsp_ready[g] is asserted combinationally for the winner only. On the handshake, sid, len and g are captured and retry_cnt is set to 0.
  - If the captured len==0: no meta is issued, the body is not consumed, last_grant is set to g, sent_count increments, and the FSM stays in IDLE.
  - Otherwise the FSM goes to META.
- META: tx_meta_valid=1 with the captured {len, sid}. On tx_meta_ready the FSM goes to STATUS.
- STATUS: tx_status_ready=1. A status beat is consumed whatever its sid.
  - err==0: go to DATA.
  - err!=0 and retry_cnt<MAX_RETRY: retry_cnt increments, go to META.
  - err!=0 and retry_cnt==MAX_RETRY: go to DROP.
- DATA:
  - Combinational pass-through of channel g: tx_data_* = body_*[g], tx_data_valid = body_valid[g], body_ready[g] = tx_data_ready.
  - On a beat handshake with body_last: sent_count increments, last_grant is set to g, go to IDLE.
- DROP: body_ready[g]=1 and tx_data_valid=0. On a body beat with last: drop_count increments, last_grant is set to g, go to IDLE.
- Non-granted channels always see rsp_ready=0 and body_ready=0.
- Counters wrap at 2^32.

## Timing
- Reset values: all outputs 0, last_grant=N_CH-1 (so channel 0 wins first), FSM=IDLE, counters 0.
- Reset mid-operation:
  - In-flight state is discarded immediately.
  - No tx output is valid while ap_rst_n=0.
  - Partially forwarded bodies are not completed.
- Minimum response latency: rsp handshake at cycle 0; tx_meta_valid at cycle 1; if tx_meta_ready is high, STATUS at cycle 2; first data beat can pass in the same cycle DATA is entered.
- Back-to-back: IDLE costs one cycle between responses; the next grant is evaluated in the cycle after the last beat.
- Once asserted, tx_meta_valid stays high with stable data until tx_meta_ready.
- tx_status beats arriving outside STATUS are back-pressured (ready=0).
- A status and a new rsp_valid in the same cycle do not interact; arbitration happens only in IDLE.
- Body length versus len is not checked; body_last alone terminates DATA and DROP.

## Configuration
- HTTP_TX_SCHED_STATS_EN defined: sent_count and drop_count are implemented as described.
- Not defined: both ports are tied to 0 and no counter registers are inferred. FSM behaviour is identical.

## Test plan
- Single response: ch0 sid=0x0005, len=64, status err=0, one beat with last → tx_meta_data={64, 5}; one tx_data beat equal to the body; sent_count=1; busy falls after the beat.
- Round-robin: ch0, ch1 and ch3 all valid at reset release → transmit order 0, 1, 3; then ch0 re-asserts while ch3 re-asserts → order 0, 3.
- Retry then success, MAX_RETRY=3: statuses err=1, err=2, err=0 → tx_meta issued 3 times with identical data; body forwarded; drop_count=0.
- Retry exhaustion: MAX_RETRY=3, four statuses err=1 → 4 metas; a 3-beat body is drained with no tx_data_valid; drop_count=1; the next channel is then served.
- Backpressure: tx_data_ready toggles 1,0,0,1 over a 4-beat body and tx_meta_ready is held low for 5 cycles → no beat lost or duplicated; tx_meta_data stable while waiting.
- Edge cases:
  - ch2 len=0 → no tx_meta; sent_count increments; ch2 body_ready stays 0.
  - Reset asserted mid-DATA → all outputs 0 within the reset; after release, ch0 is granted first.
